// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), opcode decode, and per-opcode
// execute steps (T3-T6). Control outputs are a combinational decode of the
// registered step and the IR opcode. They are forced low while Clear is held.
module control_sequencer #(
  parameter int OP_LSB    = 27,
  parameter int STEP_BITS = 4
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic [31:0]          IR,
  input  logic                 MemReady,
  input  logic                 Stop,
  output logic                 PCout,
  output logic                 MDRout,
  output logic                 Zhiout,
  output logic                 Zlowout,
  output logic                 HIout,
  output logic                 LOout,
  output logic                 Rout,
  output logic                 Rin,
  output logic                 Gra,
  output logic                 Grb,
  output logic                 Grc,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 PCin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 AND,
  output logic                 OR,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 NEG,
  output logic                 NOT,
  output logic                 Run,
  output logic [STEP_BITS-1:0] Step
);

  localparam logic [STEP_BITS-1:0] S_T0   = STEP_BITS'(0);
  localparam logic [STEP_BITS-1:0] S_T1   = STEP_BITS'(1);
  localparam logic [STEP_BITS-1:0] S_T2   = STEP_BITS'(2);
  localparam logic [STEP_BITS-1:0] S_T3   = STEP_BITS'(3);
  localparam logic [STEP_BITS-1:0] S_T4   = STEP_BITS'(4);
  localparam logic [STEP_BITS-1:0] S_T5   = STEP_BITS'(5);
  localparam logic [STEP_BITS-1:0] S_T6   = STEP_BITS'(6);
  localparam logic [STEP_BITS-1:0] S_HALT = STEP_BITS'(7);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd27;

  logic [STEP_BITS-1:0] r_step;
  logic [STEP_BITS-1:0] w_next_step;
  logic [4:0]           w_opcode;
  logic                 w_is_alu3;
  logic                 w_is_muldiv;
  logic                 w_is_negnot;
  logic                 w_op_en;
  logic                 w_unused_ir;

  assign w_opcode    = IR[OP_LSB+4:OP_LSB];
  assign w_is_alu3   = (w_opcode <= OP_ROL);
  assign w_is_muldiv = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
  assign w_is_negnot = (w_opcode == OP_NEG) || (w_opcode == OP_NOT);
  // Only the opcode field steers control; the rest of IR is datapath business.
  assign w_unused_ir = ^IR;

  assign Run   = (r_step != S_HALT);
  assign Step  = r_step;
  // No branch instructions exist, so PC is only ever advanced via IncPC.
  assign PCin  = 1'b0;

  // Step register: Clear aborts any instruction in flight and restarts fetch.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_step <= S_T0;
    end else begin
      r_step <= w_next_step;
    end
  end

  // Next-step selection; unknown encodings recover to T0.
  always_comb begin
    w_next_step = S_T0;
    case (r_step)
      S_T0:    w_next_step = Stop ? S_HALT : S_T1;
      S_T1:    w_next_step = MemReady ? S_T2 : S_T1;
      S_T2:    w_next_step = S_T3;
      S_T3: begin
        if (w_opcode == OP_HALT) begin
          w_next_step = S_HALT;
        end else if (w_is_alu3 || w_is_muldiv || w_is_negnot) begin
          w_next_step = S_T4;
        end else begin
          w_next_step = S_T0;
        end
      end
      S_T4:    w_next_step = (w_is_alu3 || w_is_muldiv) ? S_T5 : S_T0;
      S_T5:    w_next_step = w_is_muldiv ? S_T6 : S_T0;
      S_T6:    w_next_step = S_T0;
      S_HALT:  w_next_step = S_HALT;
      default: w_next_step = S_T0;
    endcase
  end

  // Control decode from step + opcode, all controls held low during Clear.
  always_comb begin
    {PCout, MDRout, Zhiout, Zlowout, HIout, LOout} = 6'b0;
    {Rout, Rin, Gra, Grb, Grc} = 5'b0;
    {MARin, MDRin, IRin, Yin, Zin, HIin, LOin} = 7'b0;
    {IncPC, Read} = 2'b0;
    {AND, OR, ADD, SUB, MUL, DIV} = 6'b0;
    {SHR, SHL, ROR, ROL, NEG, NOT} = 6'b0;
    w_op_en = 1'b0;
    if (Clear) begin
      case (r_step)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        end
        S_T1: begin
          Read = 1'b1; MDRin = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          if (w_is_alu3 || w_is_muldiv) begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end else if (w_is_negnot) begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; w_op_en = 1'b1;
          end else if (w_opcode == OP_MFHI) begin
            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (w_opcode == OP_MFLO) begin
            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else begin
            w_op_en = 1'b0;
          end
        end
        S_T4: begin
          if (w_is_alu3 || w_is_muldiv) begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; w_op_en = 1'b1;
          end else if (w_is_negnot) begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else begin
            w_op_en = 1'b0;
          end
        end
        S_T5: begin
          if (w_is_alu3) begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (w_is_muldiv) begin
            Zlowout = 1'b1; LOin = 1'b1;
          end else begin
            w_op_en = 1'b0;
          end
        end
        S_T6: begin
          if (w_is_muldiv) begin
            Zhiout = 1'b1; HIin = 1'b1;
          end else begin
            w_op_en = 1'b0;
          end
        end
        default: w_op_en = 1'b0;
      endcase
    end else begin
      w_op_en = 1'b0;
    end
    case (w_opcode)
      OP_ADD:  ADD = w_op_en;
      OP_SUB:  SUB = w_op_en;
      OP_AND:  AND = w_op_en;
      OP_OR:   OR  = w_op_en;
      OP_SHR:  SHR = w_op_en;
      OP_SHL:  SHL = w_op_en;
      OP_ROR:  ROR = w_op_en;
      OP_ROL:  ROL = w_op_en;
      OP_MUL:  MUL = w_op_en;
      OP_DIV:  DIV = w_op_en;
      OP_NEG:  NEG = w_op_en;
      OP_NOT:  NOT = w_op_en;
      default: ADD = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class step by
// step and compares the full control word, Step and Run against hand tables.
module tb_control_sequencer;

  logic        Clock, Clear, MemReady, Stop;
  logic [31:0] IR;
  logic s_pcout, s_mdrout, s_zhiout, s_zlowout, s_hiout, s_loout;
  logic s_rout, s_rin, s_gra, s_grb, s_grc;
  logic s_marin, s_mdrin, s_irin, s_yin, s_zin, s_pcin, s_hiin, s_loin;
  logic s_incpc, s_read;
  logic s_and, s_or, s_add, s_sub, s_mul, s_div;
  logic s_shr, s_shl, s_ror, s_rol, s_neg, s_not;
  logic s_run;
  logic [3:0] s_step;
  logic [32:0] ctl_obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Control word bit positions (bit 0 = PCout ... bit 32 = NOT).
  localparam logic [32:0] PCOUT = 33'd1 << 0,  MDROUT = 33'd1 << 1,  ZHIOUT = 33'd1 << 2;
  localparam logic [32:0] ZLOWOUT = 33'd1 << 3, HIOUT = 33'd1 << 4,  LOOUT = 33'd1 << 5;
  localparam logic [32:0] ROUT = 33'd1 << 6,   RIN = 33'd1 << 7,     GRA = 33'd1 << 8;
  localparam logic [32:0] GRB = 33'd1 << 9,    GRC = 33'd1 << 10,    MARIN = 33'd1 << 11;
  localparam logic [32:0] MDRIN = 33'd1 << 12, IRIN = 33'd1 << 13,   YIN = 33'd1 << 14;
  localparam logic [32:0] ZIN = 33'd1 << 15,   HIIN = 33'd1 << 17,   LOIN = 33'd1 << 18;
  localparam logic [32:0] INCPC = 33'd1 << 19, READ = 33'd1 << 20,   A_ADD = 33'd1 << 23;
  localparam logic [32:0] A_SUB = 33'd1 << 24, A_MUL = 33'd1 << 25,  A_ROL = 33'd1 << 30;
  localparam logic [32:0] A_NEG = 33'd1 << 31, A_NOT = 33'd1 << 32;
  localparam logic [32:0] C_T0 = PCOUT | MARIN | INCPC;
  localparam logic [32:0] C_T1 = READ | MDRIN;
  localparam logic [32:0] C_T2 = MDROUT | IRIN;

  assign ctl_obs = {s_not, s_neg, s_rol, s_ror, s_shl, s_shr, s_div, s_mul, s_sub, s_add,
                    s_or, s_and, s_read, s_incpc, s_loin, s_hiin, s_pcin, s_zin, s_yin,
                    s_irin, s_mdrin, s_marin, s_grc, s_grb, s_gra, s_rin, s_rout, s_loout,
                    s_hiout, s_zlowout, s_zhiout, s_mdrout, s_pcout};

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady), .Stop(Stop),
    .PCout(s_pcout), .MDRout(s_mdrout), .Zhiout(s_zhiout), .Zlowout(s_zlowout),
    .HIout(s_hiout), .LOout(s_loout), .Rout(s_rout), .Rin(s_rin),
    .Gra(s_gra), .Grb(s_grb), .Grc(s_grc), .MARin(s_marin), .MDRin(s_mdrin),
    .IRin(s_irin), .Yin(s_yin), .Zin(s_zin), .PCin(s_pcin), .HIin(s_hiin),
    .LOin(s_loin), .IncPC(s_incpc), .Read(s_read),
    .AND(s_and), .OR(s_or), .ADD(s_add), .SUB(s_sub), .MUL(s_mul), .DIV(s_div),
    .SHR(s_shr), .SHL(s_shl), .ROR(s_ror), .ROL(s_rol), .NEG(s_neg), .NOT(s_not),
    .Run(s_run), .Step(s_step)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent invariants: at most one bus source, at most one ALU op, not Rin with Rout.
  task automatic check_inv(input string tag);
    logic bus_ok, alu_ok, rr_ok;
    bus_ok = ($countones({s_pcout, s_mdrout, s_zhiout, s_zlowout, s_hiout, s_loout}) <= 1);
    alu_ok = ($countones({s_and, s_or, s_add, s_sub, s_mul, s_div,
                          s_shr, s_shl, s_ror, s_rol, s_neg, s_not}) <= 1);
    rr_ok  = !(s_rin && s_rout);
    check_val({tag, "_inv"}, {61'd0, bus_ok, alu_ok, rr_ok}, 64'd7);
  endtask

  // Compare the current cycle, then advance to 1 time unit past the next rising edge.
  task automatic step_chk(input string tag, input logic [3:0] exp_step,
                          input logic [32:0] exp_ctl, input logic exp_run);
    check_val({tag, "_step"}, {60'd0, s_step}, {60'd0, exp_step});
    check_val({tag, "_ctl"}, {31'd0, ctl_obs}, {31'd0, exp_ctl});
    check_val({tag, "_run"}, {63'd0, s_run}, {63'd0, exp_run});
    check_inv(tag);
    @(posedge Clock);
    #1;
  endtask

  // Halted cycle: controls and Run checked; Step encoding of HALT is not fixed.
  task automatic halt_chk(input string tag);
    check_val({tag, "_ctl"}, {31'd0, ctl_obs}, 64'd0);
    check_val({tag, "_run"}, {63'd0, s_run}, 64'd0);
    check_inv(tag);
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    step_chk({tag, "_t0"}, 4'd0, C_T0, 1'b1);
    step_chk({tag, "_t1"}, 4'd1, C_T1, 1'b1);
    step_chk({tag, "_t2"}, 4'd2, C_T2, 1'b1);
  endtask

  task automatic clear_pulse();
    Clear = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    #1;
  endtask

  initial begin
    Clear = 1'b0; IR = 32'h0; MemReady = 1'b1; Stop = 1'b0;
    #3;
    check_val("rst_step", {60'd0, s_step}, 64'd0);
    check_val("rst_ctl", {31'd0, ctl_obs}, 64'd0);
    check_val("rst_run", {63'd0, s_run}, 64'd1);
    @(negedge Clock);
    Clear = 1'b1;
    #1;

    // ADD: 6 cycles
    IR = 32'h0000_0000;
    fetch("add");
    step_chk("add_t3", 4'd3, GRB | ROUT | YIN, 1'b1);
    step_chk("add_t4", 4'd4, GRC | ROUT | A_ADD | ZIN, 1'b1);
    step_chk("add_t5", 4'd5, ZLOWOUT | GRA | RIN, 1'b1);

    // SUB with 3 memory wait cycles, then Clear in T4
    IR = 32'h0800_0000;
    MemReady = 1'b0;
    step_chk("sub_t0", 4'd0, C_T0, 1'b1);
    step_chk("sub_w1", 4'd1, C_T1, 1'b1);
    step_chk("sub_w2", 4'd1, C_T1, 1'b1);
    step_chk("sub_w3", 4'd1, C_T1, 1'b1);
    MemReady = 1'b1;
    step_chk("sub_t1", 4'd1, C_T1, 1'b1);
    step_chk("sub_t2", 4'd2, C_T2, 1'b1);
    step_chk("sub_t3", 4'd3, GRB | ROUT | YIN, 1'b1);
    check_val("sub_t4_ctl", {31'd0, ctl_obs}, {31'd0, GRC | ROUT | A_SUB | ZIN});
    Clear = 1'b0;
    #1;
    check_val("clr_async_ctl", {31'd0, ctl_obs}, 64'd0);
    check_val("clr_async_step", {60'd0, s_step}, 64'd0);
    check_val("clr_async_run", {63'd0, s_run}, 64'd1);
    @(negedge Clock);
    Clear = 1'b1;
    #1;

    // MUL: 7 cycles
    IR = 32'h7800_0000;
    fetch("mul");
    step_chk("mul_t3", 4'd3, GRB | ROUT | YIN, 1'b1);
    step_chk("mul_t4", 4'd4, GRC | ROUT | A_MUL | ZIN, 1'b1);
    step_chk("mul_t5", 4'd5, ZLOWOUT | LOIN, 1'b1);
    step_chk("mul_t6", 4'd6, ZHIOUT | HIIN, 1'b1);

    // ROL: top of the 3-register ALU range
    IR = 32'h3800_0000;
    fetch("rol");
    step_chk("rol_t3", 4'd3, GRB | ROUT | YIN, 1'b1);
    step_chk("rol_t4", 4'd4, GRC | ROUT | A_ROL | ZIN, 1'b1);
    step_chk("rol_t5", 4'd5, ZLOWOUT | GRA | RIN, 1'b1);

    // NEG and NOT: 5 cycles
    IR = 32'h8800_0000;
    fetch("neg");
    step_chk("neg_t3", 4'd3, GRB | ROUT | A_NEG | ZIN, 1'b1);
    step_chk("neg_t4", 4'd4, ZLOWOUT | GRA | RIN, 1'b1);
    IR = 32'h9000_0000;
    fetch("not");
    step_chk("not_t3", 4'd3, GRB | ROUT | A_NOT | ZIN, 1'b1);
    step_chk("not_t4", 4'd4, ZLOWOUT | GRA | RIN, 1'b1);

    // MFHI, MFLO, undefined 10111: 4 cycles
    IR = 32'hC000_0000;
    fetch("mfhi");
    step_chk("mfhi_t3", 4'd3, HIOUT | GRA | RIN, 1'b1);
    IR = 32'hC800_0000;
    fetch("mflo");
    step_chk("mflo_t3", 4'd3, LOOUT | GRA | RIN, 1'b1);
    IR = 32'hB800_0000;
    fetch("undef");
    step_chk("undef_t3", 4'd3, 33'd0, 1'b1);
    step_chk("undef_next", 4'd0, C_T0, 1'b1);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;

    // HALT opcode: halted for 20 cycles despite MemReady/Stop activity
    IR = 32'hD800_0000;
    fetch("halt");
    step_chk("halt_t3", 4'd3, 33'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      MemReady = i[0];
      Stop     = i[1];
      halt_chk("halted");
    end
    MemReady = 1'b1;
    Stop = 1'b0;
    clear_pulse();

    // Stop at the T0 edge: next cycle halted, no PCout
    IR = 32'h0000_0000;
    Stop = 1'b1;
    step_chk("stop_t0", 4'd0, C_T0, 1'b1);
    Stop = 1'b0;
    halt_chk("stop_halt1");
    halt_chk("stop_halt2");
    clear_pulse();
    step_chk("resume_t0", 4'd0, C_T0, 1'b1);
    step_chk("resume_t1", 4'd1, C_T1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
